xgmii_frame_gen_64: RTL and testbench

Link-partner traffic source for the 64-bit XGMII interface. It transmits complete Ethernet frames on `xgmii_txd`/`xgmii_txc`: start character, preamble/SFD, a deterministic payload, CRC-32 FCS, terminate and inter-frame gap. It drives the XGMII RX side of the 10G MAC (`xgmii_rxd`/`xgmii_rxc`) in loopback and bring-up benches, and serves as a synthesizable PHY-side stimulus in hardware.

---
 rtl/xgmii_frame_gen_64.sv | 227 ++++++++++++++++++++++
 tb/tb_xgmii_frame_gen_64.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_frame_gen_64.sv
// xgmii_frame_gen_64
//   Link-partner traffic source for a 64-bit XGMII interface. Sends complete Ethernet frames:
//   start word (FB + preamble + SFD), a counting payload starting at 'seed', CRC-32 FCS,
//   terminate character and an inter-frame gap of idle characters.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-low reset
//   start        in   frame request, accepted when busy is low
//   frame_len    in   payload bytes excluding FCS (clamped to MIN_LEN..MAX_LEN), latched on accept
//   seed         in   first payload byte, latched on accept
//   ifg_delay    in   requested gap in bytes (floored at MIN_IFG), latched on accept
//   xgmii_txd    out  XGMII data, lane k = bits [8k+7:8k]
//   xgmii_txc    out  XGMII control, one bit per lane
//   busy         out  high while a frame or its gap is in progress
//   frame_count  out  completed frames, wraps modulo 2^32

module xgmii_frame_gen_64 #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 9600,
    parameter int unsigned MIN_IFG = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] frame_len,
    input  logic [7:0]  seed,
    input  logic [7:0]  ifg_delay,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        busy,
    output logic [31:0] frame_count
);

    localparam logic [63:0] IdleData  = 64'h0707070707070707;
    localparam logic [7:0]  IdleCtrl  = 8'hFF;
    localparam logic [63:0] StartData = 64'hD5555555555555FB;
    localparam logic [7:0]  StartCtrl = 8'h01;
    localparam logic [63:0] TermData  = 64'h07070707070707FD;
    localparam logic [31:0] CrcPoly   = 32'hEDB88320;
    localparam logic [13:0] MinLen    = MIN_LEN[13:0];
    localparam logic [13:0] MaxLen    = MAX_LEN[13:0];
    localparam logic [7:0]  MinIfg    = MIN_IFG[7:0];

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StTerm,
        StIfg
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        busy_q, busy_d;
    logic [31:0] count_q, count_d;
    logic [13:0] len_q, len_d;
    logic [7:0]  seed_q, seed_d;
    logic [7:0]  gap_q, gap_d;
    logic [13:0] pos_q, pos_d;       // stream index of lane 0 in the next data word
    logic [31:0] crc_q, crc_d;       // CRC over payload bytes before pos_q
    logic [5:0]  idle_cnt_q, idle_cnt_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    // Word builder for the byte window pos_q .. pos_q+7.
    logic [31:0] crc_word;
    logic [31:0] fcs;
    logic [63:0] data_word;
    logic [7:0]  ctrl_word;
    logic [13:0] n_bytes;
    logic [13:0] lane_idx;
    logic [1:0]  fcs_sel;
    logic        last_word;
    logic [2:0]  rem;
    logic [2:0]  term_idle;
    logic [5:0]  ifg_words;

    always_comb begin
        n_bytes   = len_q + 14'd4;
        crc_word  = crc_q;
        data_word = '0;
        ctrl_word = '0;
        lane_idx  = '0;
        fcs_sel   = '0;

        // Fold this word's payload bytes in first, so FCS bytes in the same word see the final CRC.
        for (int k = 0; k < 8; k++) begin
            lane_idx = pos_q + 14'(k);
            if (lane_idx < len_q) begin
                crc_word = crc_byte(crc_word, seed_q + lane_idx[7:0]);
            end
        end
        fcs = ~crc_word;

        for (int k = 0; k < 8; k++) begin
            lane_idx = pos_q + 14'(k);
            fcs_sel  = 2'(lane_idx - len_q);
            if (lane_idx < len_q) begin
                data_word[8*k +: 8] = seed_q + lane_idx[7:0];
            end else if (lane_idx < n_bytes) begin
                data_word[8*k +: 8] = fcs[{fcs_sel, 3'b000} +: 8];
            end else if (lane_idx == n_bytes) begin
                data_word[8*k +: 8] = 8'hFD;
                ctrl_word[k]        = 1'b1;
            end else begin
                data_word[8*k +: 8] = 8'h07;
                ctrl_word[k]        = 1'b1;
            end
        end

        last_word = (n_bytes <= pos_q + 14'd8);
        rem       = n_bytes[2:0];
        // Idle bytes already in the terminate word count toward the gap.
        term_idle = (rem == 3'd0) ? 3'd7 : 3'd7 - rem;
        ifg_words = 6'(({1'b0, gap_q} + 9'd7 - {6'd0, term_idle}) >> 3);
    end

    always_comb begin
        state_d    = state_q;
        txd_d      = IdleData;
        txc_d      = IdleCtrl;
        count_d    = count_q;
        len_d      = len_q;
        seed_d     = seed_q;
        gap_d      = gap_q;
        pos_d      = pos_q;
        crc_d      = crc_q;
        idle_cnt_d = idle_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (frame_len < MinLen) begin
                        len_d = MinLen;
                    end else if (frame_len > MaxLen) begin
                        len_d = MaxLen;
                    end else begin
                        len_d = frame_len;
                    end
                    seed_d  = seed;
                    gap_d   = (ifg_delay < MinIfg) ? MinIfg : ifg_delay;
                    pos_d   = '0;
                    crc_d   = '1;
                    txd_d   = StartData;
                    txc_d   = StartCtrl;
                    state_d = StData;
                end
            end
            StData: begin
                txd_d = data_word;
                txc_d = ctrl_word;
                pos_d = pos_q + 14'd8;
                crc_d = crc_word;
                if (last_word) begin
                    if (rem == 3'd0) begin
                        state_d = StTerm;
                    end else begin
                        count_d    = count_q + 32'd1;
                        idle_cnt_d = ifg_words;
                        state_d    = StIfg;
                    end
                end
            end
            StTerm: begin
                txd_d      = TermData;
                txc_d      = IdleCtrl;
                count_d    = count_q + 32'd1;
                idle_cnt_d = ifg_words;
                state_d    = StIfg;
            end
            StIfg: begin
                idle_cnt_d = idle_cnt_q - 6'd1;
                if (idle_cnt_q <= 6'd1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // busy is low while the final gap word is on the bus so a held start follows directly.
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            txd_q      <= IdleData;
            txc_q      <= IdleCtrl;
            busy_q     <= 1'b0;
            count_q    <= '0;
            len_q      <= MinLen;
            seed_q     <= '0;
            gap_q      <= MinIfg;
            pos_q      <= '0;
            crc_q      <= '1;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            len_q      <= len_d;
            seed_q     <= seed_d;
            gap_q      <= gap_d;
            pos_q      <= pos_d;
            crc_q      <= crc_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign busy        = busy_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_xgmii_frame_gen_64.sv
// Testbench for xgmii_frame_gen_64: directed and random frames compared word by word against a
// byte-stream reference model built from the frame format rules.

module tb_xgmii_frame_gen_64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [13:0] frame_len = '0;
    logic [7:0]  seed = '0;
    logic [7:0]  ifg_delay = '0;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic [31:0] frame_count;

    always #5 clk = ~clk;

    xgmii_frame_gen_64 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_len   (frame_len),
        .seed        (seed),
        .ifg_delay   (ifg_delay),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] exp_count = '0;

    // Expected lane bytes {ctrl, data} for one frame period, starting with the start word.
    logic [8:0] exp_q[$];
    int         term_word;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input int len_req, input logic [7:0] sd, input int ifg_req);
        int          l;
        int          g;
        int          n_idle;
        logic [31:0] crc;
        logic [7:0]  b;
        l = (len_req < 60) ? 60 : ((len_req > 9600) ? 9600 : len_req);
        g = (ifg_req < 12) ? 12 : ifg_req;
        exp_q.delete();
        exp_q.push_back({1'b1, 8'hFB});
        repeat (6) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < l; i++) begin
            b = sd + 8'(i);
            exp_q.push_back({1'b0, b});
            crc = crc ^ {24'd0, b};
            for (int j = 0; j < 8; j++) begin
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
            end
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, crc[8*k +: 8]});
        end
        term_word = exp_q.size() / 8;
        exp_q.push_back({1'b1, 8'hFD});
        // Idle until at least the gap has elapsed and the word is complete.
        n_idle = 0;
        while (n_idle < g || (exp_q.size() % 8) != 0) begin
            exp_q.push_back({1'b1, 8'h07});
            n_idle++;
        end
    endtask

    // Called at a negedge with the generator idle; returns at the negedge of the final gap word.
    task automatic send_frame(input int len, input logic [7:0] sd, input int ifg, input bit hold);
        int          nw;
        logic [63:0] ed;
        logic [7:0]  ec;
        build_frame(len, sd, ifg);
        nw = exp_q.size() / 8;
        check_eq("busy_before_start", 64'(busy), 64'd0);
        frame_len = 14'(len);
        seed      = sd;
        ifg_delay = 8'(ifg);
        start     = 1'b1;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                ed[8*j +: 8] = exp_q[w*8 + j][7:0];
                ec[j]        = exp_q[w*8 + j][8];
            end
            if (w == term_word) exp_count++;
            check_eq($sformatf("txd len%0d w%0d", len, w), xgmii_txd, ed);
            check_eq($sformatf("txc len%0d w%0d", len, w), 64'(xgmii_txc), 64'(ec));
            check_eq($sformatf("busy len%0d w%0d", len, w), 64'(busy), 64'(w != nw - 1));
            check_eq($sformatf("count len%0d w%0d", len, w), 64'(frame_count), 64'(exp_count));
            // Inputs while busy must be ignored.
            frame_len = 14'($urandom);
            seed      = 8'($urandom);
            ifg_delay = 8'($urandom);
            if (!hold) start = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_txd", xgmii_txd, 64'h0707070707070707);
            check_eq("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic mid_reset();
        check_eq("busy_before_mid", 64'(busy), 64'd0);
        frame_len = 14'd200;
        seed      = 8'h01;
        ifg_delay = 8'd12;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_mid_frame", 64'(busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        exp_count = '0;
        check_eq("rst_mid_txd", xgmii_txd, 64'h0707070707070707);
        check_eq("rst_mid_txc", 64'(xgmii_txc), 64'hFF);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_count", 64'(frame_count), 64'(exp_count));
        rst = 1'b1;
        idle_cycles(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        int ifg;
        bit hold;

        // Reset with start held: start must be ignored during reset.
        rst   = 1'b0;
        start = 1'b1;
        frame_len = 14'd60;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", xgmii_txd, 64'h0707070707070707);
        check_eq("rst_txc", 64'(xgmii_txc), 64'hFF);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_count", 64'(frame_count), 64'd0);
        rst   = 1'b1;
        start = 1'b0;
        idle_cycles(2);

        // Directed frames.
        send_frame(60, 8'h00, 12, 1'b1);
        send_frame(60, 8'h00, 12, 1'b1);
        send_frame(61, 8'h00, 12, 1'b1);
        send_frame(64, 8'h33, 20, 1'b0);
        idle_cycles(2);
        send_frame(10, 8'h05, 0, 1'b0);
        send_frame(16000, 8'h80, 12, 1'b0);
        send_frame(59, 8'hAA, 11, 1'b0);
        send_frame(100, 8'hF0, 12, 1'b0);
        idle_cycles(1);

        mid_reset();
        send_frame(61, 8'h42, 30, 1'b0);

        // Random frames.
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 9))
                0:       len = int'($urandom_range(0, 16383));
                1:       len = int'($urandom_range(50, 70));
                default: len = int'($urandom_range(0, 300));
            endcase
            ifg  = int'($urandom_range(0, 255));
            hold = (f != 23) && ($urandom_range(0, 1) == 1);
            send_frame(len, 8'($urandom), ifg, hold);
            if (!hold) idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
